sram_controller: RTL and testbench

// - MEM-stage memory backend: serves 32-bit loads/stores from the EX/MEM register via an off-chip 16-bit asynchronous SRAM.
// - Each word takes two half-word accesses (low half, then high half).
// - Holds ready low while busy. Top level ORs ~ready into freeze to stall every pipeline register.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_dq_buf.sv | 12 +
 rtl/sram_controller.sv | 194 +++++++++++++++++++
 tb/tb_sram_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit over 16-bit SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state driver for the 16-bit SRAM data bus; the only driver of SRAM_DQ.
module sram_dq_buf (
  inout  wire  [15:0] dq,
  input  logic        drive_en,
  input  logic [15:0] dout,
  output logic [15:0] din
);

  assign dq  = drive_en ? dout : 16'hzzzz;
  assign din = dq;

endmodule

// File: rtl/sram_controller.sv
// MEM-stage backend: one 32-bit load/store becomes two half-word accesses on a
// 16-bit asynchronous SRAM (low half, then high half). ready stays low while busy.
// Optional macro SRAM_CTRL_ADDR_CHECK_EN adds an addr_err output and rejects
// out-of-range requests without touching the SRAM.
//
// state | meaning
// IDLE  | waiting for a request; ready=1 only when no request is present
// LO    | low half-word on the bus for WAIT_CYCLES cycles
// HI    | high half-word on the bus for WAIT_CYCLES cycles
// DONE  | ready=1 for one cycle, pipeline advances on this edge
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  output logic               addr_err,
`endif
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int             CW           = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD     = CW'(WAIT_CYCLES - 1);
  localparam bit             SINGLE_CYCLE = (WAIT_CYCLES == 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SRAM_AW-2:0]   widx_q, widx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [15:0]          lo_q, lo_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [15:0]          dq_out_q, dq_out_d;
  logic [15:0]          dq_in;

  logic                 req;
  logic [SRAM_AW-2:0]   req_widx;
  logic                 busy_d;
  logic                 half_d;

  assign req = MEM_R_EN | MEM_W_EN;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic [31:0] req_off;
  logic        req_oor;
  logic        err_q, err_d;

  assign req_off  = address - BASE_ADDR;
  assign req_widx = req_off[SRAM_AW:2];
  assign req_oor  = (address < BASE_ADDR) ||
                    ((req_off >> 2) >= (32'd1 << (SRAM_AW - 1)));
  assign addr_err = err_q;
`else
  // Word index wraps modulo the SRAM size, including addresses below BASE_ADDR.
  assign req_widx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
`endif

  sram_dq_buf u_dq_buf (
    .dq       (SRAM_DQ),
    .drive_en (dq_oe_q),
    .dout     (dq_out_q),
    .din      (dq_in)
  );

  // Next-state, counter and data-path logic; bus outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          widx_d  = req_widx;
          wdata_d = writeData;
          wr_d    = MEM_W_EN;
          cnt_d   = CNT_LOAD;
          state_d = LO;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
          if (req_oor) begin
            state_d = DONE;
            cnt_d   = '0;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      LO: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = HI;
          if (!wr_q) lo_d = dq_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HI: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) rdata_d = {dq_in, lo_q};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // WE_N rises one cycle before the phase ends so address and data are stable at the rise
    busy_d      = (state_d == LO) || (state_d == HI);
    half_d      = (state_d == HI) ? HALF_HI : HALF_LO;
    sram_addr_d = busy_d ? {widx_d, half_d} : '0;
    oe_n_d      = !(busy_d && !wr_d);
    we_n_d      = !(busy_d && wr_d && ((cnt_d != '0) || SINGLE_CYCLE));
    dq_oe_d     = busy_d && wr_d;
    dq_out_d    = !busy_d ? 16'h0000 :
                  (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
  end

  // State, counter, data and registered SRAM strobes; reset abandons any access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      widx_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      lo_q        <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // The accepting IDLE cycle already reports busy so the pipeline freezes immediately
  assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign readData  = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model, word-level reference model,
// scoreboard queue popped by a monitor on each completed request.
// Honours SRAM_CTRL_ADDR_CHECK_EN when the design is built with it.
module tb_sram_controller;

  localparam int          WC    = 2;
  localparam int          AW    = 18;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          STALL = 2 * WC + 1;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          stall;
    bit          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   address, writeData;
  logic [31:0]   readData;
  logic          ready;
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, oe_n, ce_n, ub_n, lb_n;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic          addr_err;
`endif

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          we_low_cycles = 0;
  int          oe_low_cycles = 0;

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    .addr_err  (addr_err),
`endif
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  always #5 clk = ~clk;

  // ---------------- async SRAM model ----------------
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic        pend_v = 1'b0;
  logic [AW-1:0] pend_a;
  logic [15:0] pend_d;

  assign sram_dq = (!oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;

  // A write commits when WE_N rises with address and data still held; a pulse cut short is lost
  always @(negedge clk) begin
    if (!we_n) begin
      pend_v <= 1'b1;
      pend_a <= sram_addr;
      pend_d <= sram_dq;
    end else if (pend_v) begin
      if (sram_addr == pend_a && sram_dq == pend_d) sram_mem[pend_a] <= pend_d;
      pend_v <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) / 4) % (1 << (AW - 1)));
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    return (a < BASE) || (((a - BASE) / 4) >= (1 << (AW - 1)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Present one request (held until DONE) and queue its expected completion
  task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   k;
    bit   seen_low;
    e.is_load = !w;
    e.stall   = STALL;
    e.err     = 1'b0;
    e.data    = 32'h0;
    if (out_of_range(a)) begin
      e.is_load = 1'b1;
      e.stall   = 1;
      e.err     = 1'b1;
    end else if (w) begin
      ref_mem[word_of(a)] = d;
    end else begin
      e.data = ref_rd(word_of(a));
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    MEM_W_EN = w; MEM_R_EN = r; address = a; writeData = d;
    k = 0; seen_low = 1'b0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (!ready) seen_low = 1'b1;
      else if (seen_low) break;
    end
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL op_timeout: got no DONE within %0d cycles expected completion", k);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          low_run = 0;
  int          we_run  = 0;
  logic [31:0] last_load = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!we_n) begin
      we_run++;
      we_low_cycles++;
    end else if (we_run > 0) begin
      chk("we_pulse_len", we_run, WC - 1);
      we_run = 0;
    end
    if (!oe_n) oe_low_cycles++;
    if (rst) begin
      low_run   = 0;
      last_load = 32'h0;
    end else if (!ready) begin
      low_run++;
    end else if (low_run > 0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got completion expected none");
      end else begin
        e = exp_q.pop_front();
        chk("stall_len", low_run, e.stall);
        if (e.is_load) last_load = e.data;
        chk(e.is_load ? "load_data" : "held_data", readData, last_load);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        chk("addr_err", {31'h0, addr_err}, {31'h0, e.err});
`endif
      end
      low_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  kind, gap, we0, oe0;
    logic [31:0] a, d;
    bit  found;
    int  k;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; writeData = '0;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_rdata", readData, 32'h0);
    chk("rst_we_n", {31'h0, we_n}, 32'h1);
    chk("rst_oe_n", {31'h0, oe_n}, 32'h1);
    chk("rst_dq_z", {31'h0, dut.u_dq_buf.drive_en}, 32'h0);
    chk("rst_addr", {14'h0, sram_addr}, 32'h0);
    chk("tied_lows", {29'h0, ce_n, ub_n, lb_n}, 32'h0);

    do_op(1, 0, 32'd1028, 32'hDEADBEEF);
    idle(2);
    chk("sram_half2", {16'h0, sram_mem[2]}, 32'h0000BEEF);
    chk("sram_half3", {16'h0, sram_mem[3]}, 32'h0000DEAD);
    do_op(0, 1, 32'd1028, 32'h0);
    idle(1);

    do_op(1, 0, 32'd1024, 32'h12345678);
    do_op(0, 1, 32'd1024, 32'h0);
    idle(2);

    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 2);
      a    = BASE + 4 * $urandom_range(0, 15);
      d    = $urandom;
      do_op(kind != 0, kind != 1, a, d);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    idle(2);

    do_op(1, 0, 32'd1032, 32'hCAFEF00D);
    idle(1);
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; address = 32'd1032; writeData = 32'h5A5AA5A5;
    found = 1'b0; k = 0;
    while (k < 50 && !found) begin
      @(negedge clk);
      k++;
      if (sram_addr[0] && !we_n) found = 1'b1;
    end
    chk("hi_phase_seen", {31'h0, found}, 32'h1);
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("abort_dq_z", {31'h0, dut.u_dq_buf.drive_en}, 32'h0);
    chk("abort_we_n", {31'h0, we_n}, 32'h1);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[word_of(32'd1032)] = {ref_rd(word_of(32'd1032)) >> 16, 16'hA5A5};
    do_op(0, 1, 32'd1032, 32'h0);
    idle(2);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      a    = BASE + 4 * $urandom_range(0, 7);
      d    = $urandom;
      do_op(kind != 0, kind != 1, a, d);
      if ($urandom_range(0, 1) != 0) idle(1);
    end
    idle(2);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    we0 = we_low_cycles; oe0 = oe_low_cycles;
    do_op(0, 1, 32'd1020, 32'h0);
    idle(1);
    do_op(1, 0, BASE + (32'd4 << (AW - 1)), 32'h77778888);
    idle(1);
    chk("err_no_we", we_low_cycles - we0, 32'h0);
    chk("err_no_oe", oe_low_cycles - oe0, 32'h0);
    do_op(0, 1, 32'd1024, 32'h0);
    idle(2);
`else
    we0 = 0; oe0 = 0;
    do_op(1, 0, BASE + (32'd4 << (AW - 1)) + 32'd8, 32'h0BADCAFE);
    do_op(0, 1, 32'd1032, 32'h0);
    do_op(1, 1, 32'd1020, 32'h600DD00D);
    do_op(0, 1, BASE + 4 * ((32'd1 << (AW - 1)) - 1), 32'h0);
    idle(2);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
